serial_thermo_accum: RTL and testbench

SERIAL_THERMO_ACCUM -- requirements
Module: serial_thermo_accum

---
 rtl/serial_thermo_pkg.sv | 23 ++
 rtl/serial_popcount_lane.sv | 26 ++
 rtl/serial_thermo_accum.sv | 118 +++++++++++
 tb/tb_serial_thermo_accum.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_thermo_pkg.sv
// Shared types and helpers for the serial thermometer accumulator.
// Optional build macro: SERIAL_THERMO_SCOMP_EN selects offset (signed) lane results.
package serial_thermo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Per-lane result width: clog2(frame_len)+1, so a full-frame count of ones still fits.
  function automatic int sum_width(input int frame_len);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < frame_len) begin
        w = i + 1;
      end
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/serial_popcount_lane.sv
// One serial lane: counts the ones seen while enabled. Clear has priority over enable.
module serial_popcount_lane
  import serial_thermo_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  localparam int SW = sum_width(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          bit_in,
  output logic [SW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && bit_in) begin
      count <= count + {{(SW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/serial_thermo_accum.sv
// Multi-lane serial thermometer accumulator with a valid/ready result handshake.
// Optional build macro: SERIAL_THERMO_SCOMP_EN outputs count-FRAME_LEN/2 in two's complement.
module serial_thermo_accum
  import serial_thermo_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 32,
  localparam int SW = sum_width(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [NUM_CH-1:0]    serial_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CH*SW-1:0] sum_out
);

  localparam logic [SW-1:0] LAST_IDX = SW'(FRAME_LEN - 1);

  state_t                 state;
  state_t                 state_next;
  logic [SW-1:0]          bit_cnt;
  logic                   lane_clear;
  logic                   lane_en;
  logic                   frame_done;
  logic [NUM_CH*SW-1:0]   result;

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  // Abort wins over a simultaneous last bit, so frame_done is only reachable without abort.
  always_comb begin
    state_next = state;
    lane_clear = 1'b0;
    lane_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lane_clear = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          lane_clear = 1'b1;
          state_next = IDLE;
        end else if (in_valid) begin
          lane_en = 1'b1;
          if (bit_cnt == LAST_IDX) begin
            frame_done = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            lane_clear = 1'b1;
            state_next = ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sum_out <= '0;
    end else begin
      state <= state_next;
      if (lane_clear) begin
        bit_cnt <= '0;
      end else if (lane_en) begin
        bit_cnt <= bit_cnt + {{(SW-1){1'b0}}, 1'b1};
      end
      if (frame_done) begin
        sum_out <= result;
      end
    end
  end

  // The last bit is still in flight when results latch, so fold it in combinationally.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [SW-1:0] lane_count;
    logic [SW-1:0] final_count;

    serial_popcount_lane #(
      .FRAME_LEN (FRAME_LEN)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (lane_clear),
      .enable (lane_en),
      .bit_in (serial_in[k]),
      .count  (lane_count)
    );

    assign final_count = lane_count + {{(SW-1){1'b0}}, serial_in[k]};

`ifdef SERIAL_THERMO_SCOMP_EN
    localparam logic [SW-1:0] HALF = SW'(FRAME_LEN / 2);
    assign result[k*SW +: SW] = final_count - HALF;
`else
    assign result[k*SW +: SW] = final_count;
`endif
  end

endmodule

// File: tb/tb_serial_thermo_accum.sv
// Directed self-checking bench for serial_thermo_accum (FRAME_LEN=8, NUM_CH=2).
// Expected lane values follow SERIAL_THERMO_SCOMP_EN when it is defined for the build.
module tb_serial_thermo_accum;

  localparam int NUM_CH    = 2;
  localparam int FRAME_LEN = 8;
  localparam int SW        = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic [NUM_CH-1:0]    serial_in;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_CH*SW-1:0] sum_out;

  int checks = 0;
  int errors = 0;

  serial_thermo_accum #(
    .NUM_CH    (NUM_CH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .serial_in (serial_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Lane encoding: raw count, or count - FRAME_LEN/2 in 4-bit two's complement.
  function automatic logic [31:0] lane_exp(input int cnt);
    logic [3:0] v;
`ifdef SERIAL_THERMO_SCOMP_EN
    v = 4'(cnt - FRAME_LEN / 2);
`else
    v = 4'(cnt);
`endif
    return {28'd0, v};
  endfunction

  task automatic checkResult(input string tag, input int cnt0, input int cnt1);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_lane0"}, {28'd0, sum_out[3:0]}, lane_exp(cnt0));
    checkOutput({tag, "_lane1"}, {28'd0, sum_out[7:4]}, lane_exp(cnt1));
  endtask

  // Called just after a negedge; one start cycle into ACCUM.
  task automatic startFrame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends nbits bits MSB first; with gaps a stall cycle (junk data, start high) precedes each
  // bit after the first; with abort_last the final driven bit carries abort.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                               input bit gaps, input bit abort_last);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i != 0) begin
        in_valid  = 1'b0;
        serial_in = 2'b11;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
      end
      in_valid  = 1'b1;
      serial_in = {b1[7-i], b0[7-i]};
      abort     = abort_last && (i == nbits - 1);
      if (i == FRAME_LEN - 1) begin
        checkOutput("pre_last_valid", {31'd0, out_valid}, 32'd0);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    serial_in = '0;
    abort     = 1'b0;
  endtask

  task automatic handshakeIdle(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_ack_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ack_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    serial_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {24'd0, sum_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic frame");
    startFrame();
    checkOutput("accum_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'b11110000, 8'hFF, 8, 1'b0, 1'b0);
    checkResult("basic", 4, 8);
    checkOutput("hold_busy", {31'd0, busy}, 32'd1);
    handshakeIdle("basic");

    $display("[TB] stalled frame, then held results");
    startFrame();
    applyStimulus(8'b11110000, 8'hFF, 8, 1'b1, 1'b0);
    checkResult("gaps", 4, 8);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      checkResult("hold", 4, 8);
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'h00, 8'b10100101, 8, 1'b0, 1'b0);
    checkResult("b2b", 0, 4);
    handshakeIdle("b2b");

    $display("[TB] abort cases");
    startFrame();
    applyStimulus(8'hFF, 8'hFF, 5, 1'b0, 1'b1);
    checkOutput("abort5_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort5_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort5_late_valid", {31'd0, out_valid}, 32'd0);
    startFrame();
    applyStimulus(8'hFF, 8'hFF, 8, 1'b0, 1'b1);
    checkOutput("abort_last_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_last_busy", {31'd0, busy}, 32'd0);
    startFrame();
    applyStimulus(8'b00000001, 8'b01111111, 8, 1'b0, 1'b0);
    checkResult("post_abort", 1, 7);
    handshakeIdle("post_abort");

    $display("[TB] reset mid-frame");
    startFrame();
    applyStimulus(8'hFF, 8'hFF, 3, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_sum", {24'd0, sum_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    startFrame();
    checkOutput("rst_start_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'hFF, 8'b00011000, 8, 1'b0, 1'b0);
    checkResult("post_rst", 8, 2);
    handshakeIdle("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
